customized_sequence_multi: RTL



---
 rtl/customized_sequence_pkg.sv | 23 ++
 rtl/customized_sequence_channel.sv | 105 ++++++++++
 rtl/customized_sequence_multi.sv | 76 +++++++
 3 files changed

// File: rtl/customized_sequence_pkg.sv
// Shared types and default sizing for the multi-channel pattern sequencer.
package customized_sequence_pkg;

    localparam int DEF_CH      = 4;
    localparam int DEF_MAX_LEN = 256;
    localparam int DEF_DIV_W   = 8;
    localparam int DEF_REP_W   = 8;
    localparam int DEF_LEN_W   = $clog2(DEF_MAX_LEN);

    typedef struct packed {
        logic [DEF_MAX_LEN-1:0] data;
        logic [DEF_LEN_W-1:0]   len_m1;
        logic [DEF_DIV_W-1:0]   div_m1;
        logic [DEF_REP_W-1:0]   rep;
        logic                   idle;
    } chan_cfg_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

endpackage

// File: rtl/customized_sequence_channel.sv
// One pattern channel: latches its config on start, then walks the pattern
// bit by bit at the programmed period for a fixed or unlimited number of passes.
module customized_sequence_channel
    import customized_sequence_pkg::*;
#(
    parameter int  MAX_LEN = DEF_MAX_LEN,
    parameter int  DIV_W   = DEF_DIV_W,
    parameter int  REP_W   = DEF_REP_W,
    parameter type cfg_t   = chan_cfg_t,
    localparam int LEN_W   = $clog2(MAX_LEN)
) (
    input  logic clk,
    input  logic rst_n,
    input  cfg_t start_cfg,
    input  logic start,
    input  logic stop,
    output logic seq,
    output logic busy,
    output logic done
);

    chan_state_t        state, state_n;
    cfg_t               act, act_n;
    logic [LEN_W-1:0]   bit_idx, bit_idx_n, bit_inc;
    logic [DIV_W-1:0]   div_cnt, div_cnt_n;
    logic [REP_W-1:0]   rep_cnt, rep_cnt_n;
    logic               seq_n, busy_n, done_n;

    assign bit_inc = bit_idx + LEN_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            act     <= '0;
            bit_idx <= '0;
            div_cnt <= '0;
            rep_cnt <= '0;
            seq     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            act     <= act_n;
            bit_idx <= bit_idx_n;
            div_cnt <= div_cnt_n;
            rep_cnt <= rep_cnt_n;
            seq     <= seq_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    // Stop beats start, so a simultaneous stop/start leaves the channel idle.
    always_comb begin
        state_n   = state;
        act_n     = act;
        bit_idx_n = bit_idx;
        div_cnt_n = div_cnt;
        rep_cnt_n = rep_cnt;
        seq_n     = seq;
        busy_n    = busy;
        done_n    = 1'b0;

        if (stop) begin
            if (state == RUN) begin
                state_n = IDLE;
                seq_n   = act.idle;
                busy_n  = 1'b0;
            end
        end else if (start) begin
            state_n   = RUN;
            act_n     = start_cfg;
            bit_idx_n = '0;
            div_cnt_n = '0;
            rep_cnt_n = '0;
            seq_n     = start_cfg.data[0];
            busy_n    = 1'b1;
        end else if (state == RUN) begin
            if (div_cnt != act.div_m1) begin
                div_cnt_n = div_cnt + DIV_W'(1);
            end else begin
                div_cnt_n = '0;
                if (bit_idx != act.len_m1) begin
                    bit_idx_n = bit_inc;
                    seq_n     = act.data[bit_inc];
                end else if ((act.rep != '0) && (rep_cnt == act.rep - REP_W'(1))) begin
                    state_n = IDLE;
                    seq_n   = act.idle;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    // Endless runs park the pass counter at all-ones instead of wrapping.
                    if ((act.rep == '0) && (rep_cnt == '1)) begin
                        rep_cnt_n = rep_cnt;
                    end else begin
                        rep_cnt_n = rep_cnt + REP_W'(1);
                    end
                    bit_idx_n = '0;
                    seq_n     = act.data[0];
                end
            end
        end
    end

endmodule

// File: rtl/customized_sequence_multi.sv
// Multi-channel pattern sequencer: per-channel shadow config registers with a
// same-cycle write bypass into start, feeding one sequencer channel each.
module customized_sequence_multi
    import customized_sequence_pkg::*;
#(
    parameter int  CH      = DEF_CH,
    parameter int  MAX_LEN = DEF_MAX_LEN,
    parameter int  DIV_W   = DEF_DIV_W,
    parameter int  REP_W   = DEF_REP_W,
    localparam int CH_W    = (CH > 1) ? $clog2(CH) : 1,
    localparam int LEN_W   = $clog2(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [MAX_LEN-1:0] cfg_data,
    input  logic [LEN_W-1:0]   cfg_len_m1,
    input  logic [DIV_W-1:0]   cfg_div_m1,
    input  logic [REP_W-1:0]   cfg_rep,
    input  logic               cfg_idle,
    input  logic [CH-1:0]      start,
    input  logic [CH-1:0]      stop,
    output logic [CH-1:0]      seq,
    output logic [CH-1:0]      busy,
    output logic [CH-1:0]      done
);

    typedef struct packed {
        logic [MAX_LEN-1:0] data;
        logic [LEN_W-1:0]   len_m1;
        logic [DIV_W-1:0]   div_m1;
        logic [REP_W-1:0]   rep;
        logic               idle;
    } cfg_t;

    cfg_t wr_cfg;

    assign wr_cfg = '{data: cfg_data, len_m1: cfg_len_m1, div_m1: cfg_div_m1,
                      rep: cfg_rep, idle: cfg_idle};

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic hit;
        cfg_t shadow;
        cfg_t start_cfg;

        // Out-of-range channel numbers never match any instance, so they are dropped.
        assign hit       = cfg_we && (int'(cfg_ch) == i);
        assign start_cfg = hit ? wr_cfg : shadow;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                shadow <= '0;
            end else if (hit) begin
                shadow <= wr_cfg;
            end
        end

        customized_sequence_channel #(
            .MAX_LEN (MAX_LEN),
            .DIV_W   (DIV_W),
            .REP_W   (REP_W),
            .cfg_t   (cfg_t)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .start_cfg (start_cfg),
            .start     (start[i]),
            .stop      (stop[i]),
            .seq       (seq[i]),
            .busy      (busy[i]),
            .done      (done[i])
        );
    end

endmodule
